// File: rtl/seg_glyph_pkg.sv
// rtl/seg_glyph_pkg.sv - glyph indices, active-low segment patterns and index-to-segment map
package seg_glyph_pkg;

  typedef logic [2:0] glyph_idx_t;

  localparam glyph_idx_t GLYPH_A    = 3'd0;
  localparam glyph_idx_t GLYPH_B    = 3'd1;
  localparam glyph_idx_t GLYPH_C    = 3'd2;
  localparam glyph_idx_t GLYPH_D    = 3'd3;
  localparam glyph_idx_t GLYPH_E    = 3'd4;
  localparam glyph_idx_t GLYPH_F    = 3'd5;
  localparam glyph_idx_t GLYPH_US   = 3'd6;
  localparam glyph_idx_t GLYPH_DASH = 3'd7;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_US    = 7'b1110111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] glyph_segments(input glyph_idx_t idx);
    logic [6:0] seg;
    case (idx)
      GLYPH_A:  seg = SEG_A;
      GLYPH_B:  seg = SEG_B;
      GLYPH_C:  seg = SEG_C;
      GLYPH_D:  seg = SEG_D;
      GLYPH_E:  seg = SEG_E;
      GLYPH_F:  seg = SEG_F;
      GLYPH_US: seg = SEG_US;
      default:  seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_display_shift.sv
// rtl/seg_display_shift.sv - scrolling multi-digit 7-segment buffer, digit 0 newest
module seg_display_shift
  import seg_glyph_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  push,
  input  logic [6:0]            glyph,
  input  logic                  clear,
  output logic [7*DIGITS-1:0]   seg
);

  logic [7*DIGITS-1:0] seg_q;
  logic [7*DIGITS-1:0] shifted;

  generate
    if (DIGITS == 1) begin : g_single
      assign shifted = glyph;
    end else begin : g_multi
      assign shifted = {seg_q[7*DIGITS-8:0], glyph};
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      seg_q <= {DIGITS{SEG_BLANK}};
    end else if (clear) begin
      seg_q <= {DIGITS{SEG_BLANK}};
    end else if (push) begin
      seg_q <= shifted;
    end
  end

  assign seg = seg_q;

endmodule

// File: rtl/serial_glyph_decoder.sv
// rtl/serial_glyph_decoder.sv - prefix-code bit stream to glyph decoder with idle timeout
module serial_glyph_decoder
  import seg_glyph_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  In_valid,
  input  logic                  In_bit,
  input  logic                  Clear,
  output logic [7*DIGITS-1:0]   Seg,
  output logic                  Sym_valid,
  output logic [2:0]            Sym_code,
  output logic                  Err,
  output logic                  Busy
);

  // Width stays at least 1 so TIMEOUT=0 still elaborates
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    ST_ROOT, ST_P0, ST_P1, ST_P10, ST_P11, ST_P111
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_d, abort_d;
  glyph_idx_t       idx_d;
  logic             sym_valid_q, err_q, busy_q;
  glyph_idx_t       sym_code_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == ST_ROOT) ? '0 : cnt_q;
    push_d  = 1'b0;
    abort_d = 1'b0;
    idx_d   = GLYPH_A;
    if (Clear) begin
      state_d = ST_ROOT;
      cnt_d   = '0;
    end else if (In_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_ROOT: state_d = In_bit ? ST_P1 : ST_P0;
        ST_P0: begin
          push_d  = 1'b1;
          idx_d   = In_bit ? GLYPH_B : GLYPH_A;
          state_d = ST_ROOT;
        end
        ST_P1:   state_d = In_bit ? ST_P11 : ST_P10;
        ST_P10: begin
          push_d  = 1'b1;
          idx_d   = In_bit ? GLYPH_D : GLYPH_C;
          state_d = ST_ROOT;
        end
        ST_P11: begin
          if (In_bit) begin
            state_d = ST_P111;
          end else begin
            push_d  = 1'b1;
            idx_d   = GLYPH_E;
            state_d = ST_ROOT;
          end
        end
        ST_P111: begin
          push_d  = 1'b1;
          idx_d   = In_bit ? GLYPH_US : GLYPH_F;
          state_d = ST_ROOT;
        end
        default: state_d = ST_ROOT;
      endcase
    end else if (state_q != ST_ROOT && TIMEOUT > 0) begin
      // Abort fires on the idle edge that would bring the count to TIMEOUT
      if (cnt_q == CNT_LAST) begin
        push_d  = 1'b1;
        abort_d = 1'b1;
        idx_d   = GLYPH_DASH;
        state_d = ST_ROOT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q     <= ST_ROOT;
      cnt_q       <= '0;
      sym_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      sym_code_q  <= GLYPH_A;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_valid_q <= push_d;
      err_q       <= abort_d;
      busy_q      <= (state_d != ST_ROOT);
      if (push_d) begin
        sym_code_q <= idx_d;
      end
    end
  end

  seg_display_shift #(.DIGITS(DIGITS)) u_display (
    .Clk    (Clk),
    .Resetn (Resetn),
    .push   (push_d),
    .glyph  (glyph_segments(idx_d)),
    .clear  (Clear),
    .seg    (Seg)
  );

  assign Sym_valid = sym_valid_q;
  assign Sym_code  = sym_code_q;
  assign Err       = err_q;
  assign Busy      = busy_q;

endmodule
